car_traffic: RTL

CAR_TRAFFIC -- requirements
Module: car_traffic

---
 rtl/car_traffic.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/car_traffic.sv
// Frogger-style car lanes: six cars advanced once per frame through one
// shared adder/comparator, committed together, with raccoon overlap detect.
module car_traffic #(
  parameter int SCREEN_W = 640,
  parameter int CAR_W    = 32,
  parameter int CAR_H    = 32,
  parameter int PLAYER_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [2:0] level,
  input  logic [9:0] raccoonX,
  input  logic [9:0] raccoonY,
  output logic [9:0] carX_1,
  output logic [9:0] carX_2,
  output logic [9:0] carX_3,
  output logic [9:0] carX_4,
  output logic [9:0] carX_5,
  output logic [9:0] carX_6,
  output logic [8:0] carY_1,
  output logic [8:0] carY_2,
  output logic [8:0] carY_3,
  output logic [8:0] carY_4,
  output logic [8:0] carY_5,
  output logic [8:0] carY_6,
  output logic       busy,
  output logic       hit,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    COMMIT
  } state_t;

  localparam logic [10:0] SW = 11'(SCREEN_W);
  localparam logic [10:0] CW = 11'(CAR_W);
  localparam logic [10:0] CH = 11'(CAR_H);
  localparam logic [10:0] PW = 11'(PLAYER_W);

  localparam logic [9:0] RST_X [6] = '{
    10'd0, 10'd320, 10'd128, 10'd448, 10'd64, 10'd512
  };

  localparam logic [8:0] LANE_Y [6] = '{
    9'd64, 9'd96, 9'd160, 9'd256, 9'd288, 9'd352
  };

  state_t     state;
  state_t     state_nx;
  logic [2:0] idx;
  logic [2:0] idx_nx;
  logic       start;

  logic [9:0] x_q  [6];
  logic [9:0] sh_q [6];
  logic       acc_q;
  logic [2:0] level_q;
  logic [9:0] rx_q;
  logic [9:0] ry_q;

  logic [9:0]  cur_x;
  logic [3:0]  base;
  logic [8:0]  lane;
  logic        right;
  logic [3:0]  step;
  logic [10:0] cur11;
  logic [10:0] step11;
  logic [10:0] sum;
  logic [10:0] nx;
  logic [10:0] rx11;
  logic [10:0] ry11;
  logic [10:0] cy11;
  logic        car_hit;

  assign busy  = (state != IDLE);
  assign start = frame_tick & enable & (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = UPDATE;
          idx_nx   = '0;
        end
      end
      UPDATE: begin
        if (idx == 3'd5) begin
          state_nx = COMMIT;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
      COMMIT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // Per-car constants: odd cars (idx 0,2,4) travel right.
  always_comb begin
    cur_x = '0;
    base  = 4'd1;
    lane  = '0;
    right = 1'b0;
    unique case (idx)
      3'd0: begin
        cur_x = x_q[0];
        base  = 4'd1;
        lane  = LANE_Y[0];
        right = 1'b1;
      end
      3'd1: begin
        cur_x = x_q[1];
        base  = 4'd2;
        lane  = LANE_Y[1];
      end
      3'd2: begin
        cur_x = x_q[2];
        base  = 4'd1;
        lane  = LANE_Y[2];
        right = 1'b1;
      end
      3'd3: begin
        cur_x = x_q[3];
        base  = 4'd2;
        lane  = LANE_Y[3];
      end
      3'd4: begin
        cur_x = x_q[4];
        base  = 4'd3;
        lane  = LANE_Y[4];
        right = 1'b1;
      end
      3'd5: begin
        cur_x = x_q[5];
        base  = 4'd1;
        lane  = LANE_Y[5];
      end
      default: begin
        cur_x = '0;
      end
    endcase
  end

  // Shared step adder with modular wrap on both edges.
  always_comb begin
    step   = base + {1'b0, level_q};
    cur11  = {1'b0, cur_x};
    step11 = {7'b0, step};
    sum    = '0;
    nx     = '0;
    if (right) begin
      sum = cur11 + step11;
      nx  = (sum >= SW) ? (sum - SW) : sum;
    end else if (cur11 < step11) begin
      nx = cur11 + SW - step11;
    end else begin
      nx = cur11 - step11;
    end
  end

  always_comb begin
    rx11    = {1'b0, rx_q};
    ry11    = {1'b0, ry_q};
    cy11    = {2'b0, lane};
    car_hit = (rx11 < nx + CW) &&
              (nx < rx11 + PW) &&
              (ry11 < cy11 + CH) &&
              (cy11 < ry11 + PW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        x_q[i]  <= RST_X[i];
        sh_q[i] <= RST_X[i];
      end
      acc_q   <= 1'b0;
      hit     <= 1'b0;
      overrun <= 1'b0;
      level_q <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
    end else begin
      hit <= 1'b0;
      if (frame_tick && busy) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            level_q <= level;
            rx_q    <= raccoonX;
            ry_q    <= raccoonY;
            acc_q   <= 1'b0;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) begin
              sh_q[i] <= nx[9:0];
            end
          end
          acc_q <= acc_q | car_hit;
        end
        COMMIT: begin
          for (int i = 0; i < 6; i++) begin
            x_q[i] <= sh_q[i];
          end
          hit   <= acc_q;
          acc_q <= 1'b0;
        end
        default: begin
          acc_q <= 1'b0;
        end
      endcase
    end
  end

  assign carX_1 = x_q[0];
  assign carX_2 = x_q[1];
  assign carX_3 = x_q[2];
  assign carX_4 = x_q[3];
  assign carX_5 = x_q[4];
  assign carX_6 = x_q[5];

  assign carY_1 = LANE_Y[0];
  assign carY_2 = LANE_Y[1];
  assign carY_3 = LANE_Y[2];
  assign carY_4 = LANE_Y[3];
  assign carY_5 = LANE_Y[4];
  assign carY_6 = LANE_Y[5];

endmodule
